fma_operand_issuer: RTL

//  Initiator side of the FMA operand/answer protocol. On a host start, reads paired operands
//  A[row][k], B[k][col] (k = 0..len-1) from the register file and issues them to the FMA unit

---
 rtl/fma_pkg.sv | 20 ++
 rtl/fma_operand_channel.sv | 43 ++++
 rtl/fma_operand_issuer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared sizing, float alias and state encoding for the FMA operand issuer.
package fma_pkg;
  localparam int FP              = 32;
  localparam int M               = 3;
  localparam int N               = 3;
  localparam int MBITS           = $clog2(M) - 1;
  localparam int NBITS           = $clog2(N) - 1;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef logic [FP-1:0] float_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH       = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ANSWER = 3'd3,
    DONE        = 3'd4,
    ERROR       = 3'd5
  } issue_state_e;
endpackage

// File: rtl/fma_operand_channel.sv
// One operand channel towards the FMA: holds data and req until a cycle with busy low,
// then drops req and remembers completion until the next launch.
module fma_operand_channel
  import fma_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   launch,
  input  float_t load_data,
  input  logic   busy,
  output float_t data,
  output logic   req,
  output logic   done
);
  float_t data_r;
  logic   req_r;
  logic   done_r;

  // Hold register: flush beats launch, launch beats transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {FP{1'b0}};
      req_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (flush) begin
      req_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (launch) begin
      data_r <= load_data;
      req_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (req_r && !busy) begin
      req_r  <= 1'b0;
      done_r <= 1'b1;
    end
  end

  assign data = data_r;
  assign req  = req_r;
  // Counts the accepting cycle itself so the next fetch is not delayed a cycle
  assign done = done_r | (req_r & ~busy);
endmodule

// File: rtl/fma_operand_issuer.sv
// Dot-product initiator: fetches A[row][k]/B[k][col] pairs, issues them to the FMA over
// two req/busy channels, then waits for the answer and reports it with sticky flags.
module fma_operand_issuer
  import fma_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             clear_in,
  input  logic [MBITS:0]   row_in,
  input  logic [NBITS:0]   col_in,
  input  logic [NBITS+1:0] len_in,
  output logic             rd_en_out,
  output logic [MBITS:0]   rd_row_out,
  output logic [NBITS:0]   rd_col_out,
  output logic [NBITS:0]   rd_k_out,
  input  float_t           a_data_in,
  input  float_t           b_data_in,
  output float_t           float_0_out,
  output logic             float_0_req_out,
  input  logic             float_0_busy_in,
  output float_t           float_1_out,
  output logic             float_1_req_out,
  input  logic             float_1_busy_in,
  input  logic             ready_answer_in,
  input  float_t           float_answer_in,
  input  logic             overflow_in,
  input  logic             underflow_in,
  output float_t           result_out,
  output logic             result_valid_out,
  output logic             overflow_flag_out,
  output logic             underflow_flag_out,
  output logic             error_out,
  output logic             busy_out,
  output logic [2:0]       state_out
);
  localparam int LW = NBITS + 2;
  localparam int CW = $clog2(TIMEOUT);

  issue_state_e     state_r, next_s;
  logic             launch_r;
  logic [MBITS:0]   row_r;
  logic [NBITS:0]   col_r, k_r;
  logic [LW-1:0]    len_r;
  logic [CW-1:0]    cnt_r;
  float_t           result_r;
  logic             ovf_r, unf_r;
  logic             done0_s, done1_s, flush_s, len_ok_s, last_s, accept_s;

  assign len_ok_s = (len_in != {LW{1'b0}}) && (len_in <= LW'(N));
  assign last_s   = (LW'(k_r) == (len_r - LW'(1'b1)));
  assign accept_s = (state_r == IDLE) && (next_s == FETCH);
  assign flush_s  = (state_r == ISSUE) && (next_s != ISSUE);

  fma_operand_channel u_ch0 (
    .clk(clk), .rst(rst), .flush(flush_s), .launch(launch_r), .load_data(a_data_in),
    .busy(float_0_busy_in), .data(float_0_out), .req(float_0_req_out), .done(done0_s)
  );

  fma_operand_channel u_ch1 (
    .clk(clk), .rst(rst), .flush(flush_s), .launch(launch_r), .load_data(b_data_in),
    .busy(float_1_busy_in), .data(float_1_out), .req(float_1_req_out), .done(done1_s)
  );

  // Next-state logic; an unsolicited answer is a protocol error everywhere but WAIT_ANSWER
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ready_answer_in)  next_s = ERROR;
        else if (start_in)    next_s = len_ok_s ? FETCH : ERROR;
        else                  next_s = IDLE;
      end
      FETCH: begin
        if (ready_answer_in)  next_s = ERROR;
        else                  next_s = ISSUE;
      end
      ISSUE: begin
        if (ready_answer_in)                         next_s = ERROR;
        else if (!launch_r && done0_s && done1_s)    next_s = last_s ? WAIT_ANSWER : FETCH;
        else                                         next_s = ISSUE;
      end
      WAIT_ANSWER: begin
        if (ready_answer_in)                   next_s = DONE;
        else if (cnt_r == CW'(TIMEOUT - 1))    next_s = ERROR;
        else                                   next_s = WAIT_ANSWER;
      end
      DONE: begin
        if (ready_answer_in)  next_s = ERROR;
        else                  next_s = IDLE;
      end
      ERROR: begin
        if (clear_in)         next_s = IDLE;
        else                  next_s = ERROR;
      end
      default:                next_s = IDLE;
    endcase
  end

  // State, job context, wait counter and captured answer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      launch_r <= 1'b0;
      row_r    <= {(MBITS+1){1'b0}};
      col_r    <= {(NBITS+1){1'b0}};
      k_r      <= {(NBITS+1){1'b0}};
      len_r    <= {LW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {FP{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state_r  <= next_s;
      launch_r <= (state_r == FETCH) && (next_s == ISSUE);
      cnt_r    <= (state_r == WAIT_ANSWER) ? cnt_r + CW'(1'b1) : {CW{1'b0}};
      if (accept_s) begin
        row_r <= row_in;
        col_r <= col_in;
        len_r <= len_in;
        k_r   <= {(NBITS+1){1'b0}};
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else if ((state_r == ISSUE) && (next_s == FETCH)) begin
        k_r <= k_r + (NBITS+1)'(1'b1);
      end else if ((state_r == WAIT_ANSWER) && ready_answer_in) begin
        result_r <= float_answer_in;
        ovf_r    <= ovf_r | overflow_in;
        unf_r    <= unf_r | underflow_in;
      end
    end
  end

  assign rd_en_out          = (state_r == FETCH);
  assign rd_row_out         = row_r;
  assign rd_col_out         = col_r;
  assign rd_k_out           = k_r;
  assign result_out         = result_r;
  assign result_valid_out   = (state_r == DONE);
  assign overflow_flag_out  = ovf_r;
  assign underflow_flag_out = unf_r;
  assign error_out          = (state_r == ERROR);
  assign busy_out           = (state_r != IDLE);
  assign state_out          = state_r;
endmodule
